pktbuf_rd_arbiter: RTL and testbench
====================================

Name: pktbuf_rd_arbiter

Overview:
- Shares the single packet-buffer read port between two burst requesters: requester 0 is the data mover and requester 1 is a secondary reader such as a replay or debug engine.
- Each granted request is a burst of consecutive flit reads. The arbiter sequences the burst one read per cycle and routes in-order read returns back to the requester that issued them.
- Sits between the requesters and the pkt_buffer read port: pkt_buffer_readaddress, pkt_buffer_read, pkt_buffer_readvalid, pkt_buffer_readdata.

Parameters:
- AWIDTH, 12, packet-buffer flit address width (PKTBUF_AWIDTH).
- DWIDTH, 520, flit width in bits (matches $bits(flit_t)).
- LWIDTH, 6, burst length field width, in flits.
- MAX_OUTSTANDING, 8, capacity of the owner FIFO, i.e. maximum reads in flight; power of 2.

Ports:
- Clk  in  1  single clock.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester burst request.
- req_addr0, req_addr1  in  AWIDTH  burst start address.
- req_len0, req_len1  in  LWIDTH  burst length in flits.
- req_ready  out  2  one-hot accept of the request.
- req_done  out  2  one-cycle pulse on the cycle the last read of the burst is issued.
- rd_valid  out  2  routed read-return valid.
- rd_data  out  DWIDTH  returned flit, shared by both requesters and qualified by rd_valid.
- pkt_buffer_readaddress  out  AWIDTH  memory read address.
- pkt_buffer_read  out  1  memory read strobe.
- pkt_buffer_readvalid  in  1  memory return valid; returns arrive in issue order with arbitrary latency.
- pkt_buffer_readdata  in  DWIDTH  memory return data.
- err_orphan  out  1  sticky flag: a readvalid arrived while the owner FIFO was empty.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1 (so requester 0 wins first); owner FIFO empty; address and count registers 0.
- Handshake: a request is accepted when req_valid[i] & req_ready[i]. req_ready is asserted only in IDLE, only for the granted requester, and combinationally from the registered state. Requesters hold valid, addr and len stable until accepted.

Arbitration:
- Round-robin at burst granularity.
- With both requesting in IDLE, the requester not equal to last_grant wins.
- last_grant updates on acceptance.

FSM:
- IDLE → BURST on acceptance with len≠0. Owner, address and remaining count (=len) are latched.
- Acceptance with len==0: req_done pulses on the acceptance cycle, no read is issued, and the state stays IDLE.
- BURST:
  - Each cycle the owner FIFO is not full: assert pkt_buffer_read, drive pkt_buffer_readaddress=cur_addr, push the owner id into the FIFO, cur_addr+=1, count-=1.
  - cur_addr wraps modulo 2^AWIDTH, so 0xFFF+1 → 0x000 at AWIDTH=12.
  - When the owner FIFO is full, pkt_buffer_read=0 and the FSM holds.
  - The read that drives count to 0 also pulses req_done[owner] in that same cycle. The FSM returns to IDLE the next cycle, so there is at least one idle cycle between bursts.
- Latency: first read is issued the cycle after acceptance (1 cycle).

Return path:
- On pkt_buffer_readvalid, pop the owner FIFO.
- Assert rd_valid[owner] and drive rd_data=pkt_buffer_readdata, registered: exactly 1 cycle from readvalid to rd_valid.
- There is no backpressure on the return path.
- Simultaneous push and pop in the same cycle is legal, including when the FIFO is full: a pop frees a slot the same cycle, so the issue is allowed.
- readvalid with the FIFO empty: the data is dropped, no rd_valid is asserted, and err_orphan is set. err_orphan clears only on Rst.

Reset mid-burst:
- Burst abandoned with no req_done; owner FIFO flushed.
- Returns arriving after reset are orphans: dropped, and err_orphan set.

Optional Feature:
Macro: PKTBUF_RD_ARB_STATS_EN.
- Defined: adds outputs stats_bursts0, stats_bursts1 (32 bits each, incremented per accepted burst including len==0) and stats_stall (32 bits, incremented each BURST cycle blocked by a full owner FIFO). All three reset to 0 and wrap at 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single burst: req0 with addr=0x010, len=4, memory latency 3 → reads at 0x010–0x013 on 4 consecutive cycles starting 1 cycle after accept; req_done[0] on the 4th read; rd_valid[0]×4 carrying the data in order.
- Contention: both request in IDLE after reset → req0 granted first, then req1, then req0 again. Return routing is correct with interleaved owners in flight (req0 len=2, req1 len=3, latency 5).
- Backpressure: MAX_OUTSTANDING=8, len=20, memory latency 30 → exactly 8 reads issue, then pkt_buffer_read stays low until the first readvalid. stats_stall counts the blocked cycles (with PKTBUF_RD_ARB_STATS_EN defined).
- Wrap and zero length: addr=0xFFE, len=3 → addresses 0xFFE, 0xFFF, 0x000. A following len=0 request → req_done the same cycle as accept, no read.
- Reset mid-burst: Rst asserted after 2 of 6 reads → no further reads, no req_done. The 2 late readvalids give no rd_valid and err_orphan=1; a burst after reset operates normally.

Source files
------------

// File: rtl/pktbuf_rd_arbiter_if.sv
// pktbuf_rd_arbiter_if: requester burst handshake plus packet-buffer read port.
// Stats outputs exist only when PKTBUF_RD_ARB_STATS_EN is defined.
interface pktbuf_rd_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 520,
  parameter int LWIDTH = 6
);
  logic [1:0]        req_valid;
  logic [AWIDTH-1:0] req_addr0;
  logic [AWIDTH-1:0] req_addr1;
  logic [LWIDTH-1:0] req_len0;
  logic [LWIDTH-1:0] req_len1;
  logic [1:0]        req_ready;
  logic [1:0]        req_done;
  logic [1:0]        rd_valid;
  logic [DWIDTH-1:0] rd_data;
  logic [AWIDTH-1:0] pkt_buffer_readaddress;
  logic              pkt_buffer_read;
  logic              pkt_buffer_readvalid;
  logic [DWIDTH-1:0] pkt_buffer_readdata;
  logic              err_orphan;
`ifdef PKTBUF_RD_ARB_STATS_EN
  logic [31:0] stats_bursts0;
  logic [31:0] stats_bursts1;
  logic [31:0] stats_stall;
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_len0, req_len1, pkt_buffer_readvalid, pkt_buffer_readdata,
    output req_ready, req_done, rd_valid, rd_data, pkt_buffer_readaddress, pkt_buffer_read, err_orphan,
           stats_bursts0, stats_bursts1, stats_stall
  );
  modport master (
    output req_valid, req_addr0, req_addr1, req_len0, req_len1, pkt_buffer_readvalid, pkt_buffer_readdata,
    input  req_ready, req_done, rd_valid, rd_data, pkt_buffer_readaddress, pkt_buffer_read, err_orphan,
           stats_bursts0, stats_bursts1, stats_stall
  );
`else
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_len0, req_len1, pkt_buffer_readvalid, pkt_buffer_readdata,
    output req_ready, req_done, rd_valid, rd_data, pkt_buffer_readaddress, pkt_buffer_read, err_orphan
  );
  modport master (
    output req_valid, req_addr0, req_addr1, req_len0, req_len1, pkt_buffer_readvalid, pkt_buffer_readdata,
    input  req_ready, req_done, rd_valid, rd_data, pkt_buffer_readaddress, pkt_buffer_read, err_orphan
  );
`endif
endinterface

// File: rtl/pktbuf_rd_arbiter.sv
// pktbuf_rd_arbiter: round-robin burst arbiter sharing the packet-buffer read port between two requesters.
// Define PKTBUF_RD_ARB_STATS_EN to add burst and stall counters.
module pktbuf_rd_arbiter #(
  parameter int AWIDTH          = 12,
  parameter int DWIDTH          = 520,
  parameter int LWIDTH          = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic clk,
  input logic rst,
  pktbuf_rd_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int UW = PW + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t               state;
  logic                 last_grant, owner, pick, accept, issue, pop, full, empty;
  logic [AWIDTH-1:0]    cur_addr;
  logic [LWIDTH-1:0]    count, len_sel;
  logic [MAX_OUTSTANDING-1:0] fifo;
  logic [PW-1:0]        wp, rp;
  logic [UW-1:0]        used;
  always_comb begin
    pick = &bus.req_valid ? ~last_grant : bus.req_valid[1];
    accept = !rst && state == IDLE && |bus.req_valid;
    len_sel = pick ? bus.req_len1 : bus.req_len0;
    empty = used == '0;
    full = used == UW'(MAX_OUTSTANDING);
    pop = bus.pkt_buffer_readvalid && !empty;
    // a same-cycle return frees a slot, so a full FIFO does not block when popping
    issue = !rst && state == BURST && (!full || pop);
    bus.req_ready = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;
    bus.req_done = accept && len_sel == '0 ? bus.req_ready :
                   issue && count == LWIDTH'(1) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    bus.pkt_buffer_read = issue;
    bus.pkt_buffer_readaddress = issue ? cur_addr : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      owner <= 1'b0;
      cur_addr <= '0;
      count <= '0;
      fifo <= '0;
      wp <= '0;
      rp <= '0;
      used <= '0;
      bus.rd_valid <= '0;
      bus.rd_data <= '0;
      bus.err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= pick;
        owner <= pick;
        cur_addr <= pick ? bus.req_addr1 : bus.req_addr0;
        count <= len_sel;
        if (len_sel != '0) state <= BURST;
      end
      if (issue) begin
        fifo[wp] <= owner;
        wp <= wp + PW'(1);
        cur_addr <= cur_addr + AWIDTH'(1);
        count <= count - LWIDTH'(1);
        if (count == LWIDTH'(1)) state <= IDLE;
      end
      if (pop) rp <= rp + PW'(1);
      used <= used + UW'(issue) - UW'(pop);
      bus.rd_valid <= pop ? (fifo[rp] ? 2'b10 : 2'b01) : 2'b00;
      if (pop) bus.rd_data <= bus.pkt_buffer_readdata;
      if (bus.pkt_buffer_readvalid && empty) bus.err_orphan <= 1'b1;
    end
  end
`ifdef PKTBUF_RD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stats_bursts0 <= '0;
      bus.stats_bursts1 <= '0;
      bus.stats_stall <= '0;
    end else begin
      if (accept && !pick) bus.stats_bursts0 <= bus.stats_bursts0 + 32'd1;
      if (accept && pick) bus.stats_bursts1 <= bus.stats_bursts1 + 32'd1;
      if (state == BURST && !issue) bus.stats_stall <= bus.stats_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pktbuf_rd_arbiter.sv
// tb_pktbuf_rd_arbiter: directed bench for pktbuf_rd_arbiter with a fixed-latency in-order memory model.
// Stats checks are compiled only when PKTBUF_RD_ARB_STATS_EN is defined.
module tb_pktbuf_rd_arbiter;
  localparam int AW = 12;
  localparam int DW = 520;
  localparam int LW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pktbuf_rd_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus ();
  pktbuf_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .MAX_OUTSTANDING(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {int c; logic [AW-1:0] a;} ev_t;
  typedef struct {int c; logic [1:0] v; logic [DW-1:0] d;} ret_t;
  ev_t  iss[$], pend[$], e_iss[$];
  ret_t rets[$], dones[$], accs[$], e_ret[$], e_done[$], e_acc[$];
  int cyc = 0;
  int lat = 3;
  int errs = 0;
  int checks = 0;
  int c0;
  logic [1:0] acc;
  function automatic logic [DW-1:0] mk(logic [AW-1:0] a);
    return {a, {(DW - 2 * AW){1'b1}}, ~a};
  endfunction
  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock cycle: drive memory return, sample combinational outputs, then registered outputs
  task automatic tick();
    if (pend.size() > 0 && pend[0].c <= cyc) begin
      bus.pkt_buffer_readvalid = 1'b1;
      bus.pkt_buffer_readdata = mk(pend[0].a);
      void'(pend.pop_front());
    end else begin
      bus.pkt_buffer_readvalid = 1'b0;
      bus.pkt_buffer_readdata = '0;
    end
    #1;
    if (bus.pkt_buffer_read) begin
      iss.push_back('{cyc, bus.pkt_buffer_readaddress});
      pend.push_back('{cyc + lat, bus.pkt_buffer_readaddress});
    end
    if (|bus.req_done) dones.push_back('{cyc, bus.req_done, '0});
    acc = bus.req_valid & bus.req_ready;
    if (|acc) accs.push_back('{cyc, acc, '0});
    @(posedge clk);
    #1;
    cyc++;
    bus.req_valid = bus.req_valid & ~acc;
    if (|bus.rd_valid) rets.push_back('{cyc, bus.rd_valid, bus.rd_data});
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask
  task automatic clr();
    iss.delete(); rets.delete(); dones.delete(); accs.delete();
    e_iss.delete(); e_ret.delete(); e_done.delete(); e_acc.delete();
  endtask
  task automatic exp_rd(int c, logic [AW-1:0] a, logic o);
    e_iss.push_back('{c, a});
    e_ret.push_back('{c + lat + 1, o ? 2'b10 : 2'b01, mk(a)});
  endtask
  task automatic ex_acc(int c, logic [1:0] v);
    e_acc.push_back('{c, v, '0});
  endtask
  task automatic ex_done(int c, logic [1:0] v);
    e_done.push_back('{c, v, '0});
  endtask
  task automatic cmp_q(string t, input ret_t got[$], input ret_t exp[$]);
    chk({t, " count"}, got.size(), exp.size());
    foreach (exp[k]) if (k < got.size()) begin
      chk($sformatf("%s%0d cycle", t, k), got[k].c, exp[k].c);
      chk($sformatf("%s%0d value", t, k), got[k].v, exp[k].v);
      chk($sformatf("%s%0d data", t, k), got[k].d, exp[k].d);
    end
  endtask
  task automatic compare(string t);
    chk({t, " reads"}, iss.size(), e_iss.size());
    foreach (e_iss[k]) if (k < iss.size()) begin
      chk($sformatf("%s read%0d cycle", t, k), iss[k].c, e_iss[k].c);
      chk($sformatf("%s read%0d addr", t, k), iss[k].a, e_iss[k].a);
    end
    cmp_q({t, " ret"}, rets, e_ret);
    cmp_q({t, " done"}, dones, e_done);
    cmp_q({t, " acc"}, accs, e_acc);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.req_len0 = '0;
    bus.req_len1 = '0;
    bus.pkt_buffer_readvalid = 1'b0;
    bus.pkt_buffer_readdata = '0;
    do_reset();
    #1;
    chk("rst req_ready", bus.req_ready, 2'b00);
    chk("rst req_done", bus.req_done, 2'b00);
    chk("rst rd_valid", bus.rd_valid, 2'b00);
    chk("rst rd_data", bus.rd_data, '0);
    chk("rst read", bus.pkt_buffer_read, 1'b0);
    chk("rst readaddress", bus.pkt_buffer_readaddress, '0);
    chk("rst err_orphan", bus.err_orphan, 1'b0);
`ifdef PKTBUF_RD_ARB_STATS_EN
    chk("rst stats", {bus.stats_bursts0, bus.stats_bursts1, bus.stats_stall}, '0);
`endif
    // single burst, latency 3
    clr();
    lat = 3;
    bus.req_addr0 = 12'h010; bus.req_len0 = 6'd4; bus.req_valid = 2'b01;
    c0 = cyc;
    run(12);
    ex_acc(c0, 2'b01);
    for (int k = 0; k < 4; k++) exp_rd(c0 + 1 + k, AW'(12'h010 + k), 1'b0);
    ex_done(c0 + 4, 2'b01);
    compare("single");
    // contention after reset: req0, req1, req0 with interleaved owners in flight
    do_reset();
    clr();
    lat = 5;
    bus.req_addr0 = 12'h100; bus.req_len0 = 6'd2;
    bus.req_addr1 = 12'h200; bus.req_len1 = 6'd3;
    bus.req_valid = 2'b11;
    c0 = cyc;
    tick();
    bus.req_addr0 = 12'h300; bus.req_len0 = 6'd1; bus.req_valid[0] = 1'b1;
    run(16);
    ex_acc(c0, 2'b01); ex_acc(c0 + 3, 2'b10); ex_acc(c0 + 7, 2'b01);
    exp_rd(c0 + 1, 12'h100, 1'b0); exp_rd(c0 + 2, 12'h101, 1'b0);
    exp_rd(c0 + 4, 12'h200, 1'b1); exp_rd(c0 + 5, 12'h201, 1'b1); exp_rd(c0 + 6, 12'h202, 1'b1);
    exp_rd(c0 + 8, 12'h300, 1'b0);
    ex_done(c0 + 2, 2'b01); ex_done(c0 + 6, 2'b10); ex_done(c0 + 8, 2'b01);
    compare("contend");
`ifdef PKTBUF_RD_ARB_STATS_EN
    chk("contend bursts0", bus.stats_bursts0, 32'd2);
    chk("contend bursts1", bus.stats_bursts1, 32'd1);
    chk("contend stall", bus.stats_stall, 32'd0);
`endif
    // backpressure: 8 outstanding, latency 30, len 20
    clr();
    lat = 30;
    bus.req_addr0 = 12'h040; bus.req_len0 = 6'd20; bus.req_valid = 2'b01;
    c0 = cyc;
    run(100);
    ex_acc(c0, 2'b01);
    for (int k = 0; k < 8; k++) exp_rd(c0 + 1 + k, AW'(12'h040 + k), 1'b0);
    for (int k = 0; k < 8; k++) exp_rd(c0 + 31 + k, AW'(12'h048 + k), 1'b0);
    for (int k = 0; k < 4; k++) exp_rd(c0 + 61 + k, AW'(12'h050 + k), 1'b0);
    ex_done(c0 + 64, 2'b01);
    compare("bp");
`ifdef PKTBUF_RD_ARB_STATS_EN
    chk("bp stall", bus.stats_stall, 32'd44);
    chk("bp bursts0", bus.stats_bursts0, 32'd3);
`endif
    // address wrap, then zero-length request, then immediate follow-up burst
    clr();
    lat = 2;
    bus.req_addr1 = 12'hFFE; bus.req_len1 = 6'd3; bus.req_valid = 2'b10;
    c0 = cyc;
    tick();
    bus.req_addr0 = 12'h123; bus.req_len0 = 6'd0;
    bus.req_addr1 = 12'h555; bus.req_len1 = 6'd1;
    bus.req_valid = 2'b11;
    run(10);
    ex_acc(c0, 2'b10); ex_acc(c0 + 4, 2'b01); ex_acc(c0 + 5, 2'b10);
    exp_rd(c0 + 1, 12'hFFE, 1'b1); exp_rd(c0 + 2, 12'hFFF, 1'b1); exp_rd(c0 + 3, 12'h000, 1'b1);
    exp_rd(c0 + 6, 12'h555, 1'b1);
    ex_done(c0 + 3, 2'b10); ex_done(c0 + 4, 2'b01); ex_done(c0 + 6, 2'b10);
    compare("wrap");
`ifdef PKTBUF_RD_ARB_STATS_EN
    chk("wrap bursts0", bus.stats_bursts0, 32'd4);
    chk("wrap bursts1", bus.stats_bursts1, 32'd3);
`endif
    // reset after 2 of 6 reads; late returns become orphans
    clr();
    lat = 10;
    bus.req_addr0 = 12'h080; bus.req_len0 = 6'd6; bus.req_valid = 2'b01;
    c0 = cyc;
    run(3);
    do_reset();
    run(5);
    chk("orphan before", bus.err_orphan, 1'b0);
    run(4);
    chk("orphan after", bus.err_orphan, 1'b1);
    ex_acc(c0, 2'b01);
    e_iss.push_back('{c0 + 1, 12'h080});
    e_iss.push_back('{c0 + 2, 12'h081});
    compare("midrst");
    clr();
    lat = 3;
    bus.req_addr0 = 12'h0A0; bus.req_len0 = 6'd2; bus.req_valid = 2'b01;
    c0 = cyc;
    run(10);
    ex_acc(c0, 2'b01);
    exp_rd(c0 + 1, 12'h0A0, 1'b0); exp_rd(c0 + 2, 12'h0A1, 1'b0);
    ex_done(c0 + 2, 2'b01);
    compare("postrst");
    chk("orphan sticky", bus.err_orphan, 1'b1);
`ifdef PKTBUF_RD_ARB_STATS_EN
    chk("postrst bursts0", bus.stats_bursts0, 32'd1);
    chk("postrst bursts1", bus.stats_bursts1, 32'd0);
    chk("postrst stall", bus.stats_stall, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
